// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: load/store unit driving the word-wide data_ port, with RMW sub-word stores and big-endian lanes.
// Optional MIPS_LSU_LWLR_EN enables LWL/LWR; without it op 8/9 report err.
module mips_cpu_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_type,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    input  logic [31:0]       op_rt,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              err,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_read,
    output logic              data_write,
    output logic [31:0]       data_writedata,
    input  logic [31:0]       data_readdata
);
    localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LW = 4'd4;
    localparam logic [3:0] OP_SB = 4'd5, OP_SH = 4'd6, OP_SW = 4'd7, OP_LWL = 4'd8, OP_LWR = 4'd9;
`ifdef MIPS_LSU_LWLR_EN
    localparam bit LWLR = 1'b1;
`else
    localparam bit LWLR = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
    state_t state, state_nx;

    logic [3:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rt, rmw_word, ld_val, merged, mask, lane;
    logic              r_err, bad;
    logic [1:0]        k;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    assign k = r_addr[1:0];

    always_comb begin
        bad = 1'b0;
        case (op_type)
            OP_LB, OP_LBU, OP_SB:  bad = 1'b0;
            OP_LH, OP_LHU, OP_SH:  bad = op_addr[0];
            OP_LW, OP_SW:          bad = |op_addr[1:0];
            OP_LWL, OP_LWR:        bad = !LWLR;
            default:               bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nx       = state;
        op_ready       = 1'b0;
        done           = 1'b0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid)
                    state_nx = bad ? RESP :
                               (op_type == OP_SW) ? WR :
                               (op_type == OP_SB || op_type == OP_SH) ? RMW_RD : RD;
            end
            RD:     begin data_read  = 1'b1; state_nx = RESP;   end
            WR:     begin data_write = 1'b1; state_nx = RESP;   end
            RMW_RD: begin data_read  = 1'b1; state_nx = RMW_WR; end
            RMW_WR: begin data_write = 1'b1; state_nx = RESP;   end
            RESP:   begin done       = 1'b1; state_nx = IDLE;   end
            default: state_nx = IDLE;
        endcase
    end

    assign err          = done & r_err;
    assign data_address = {r_addr[ADDR_W-1:2], 2'b00};

    // Lane 0 is the most significant byte of the word
    assign byte_v = data_readdata[{~k, 3'b000} +: 8];
    assign half_v = data_readdata[{~k[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = data_readdata;
        case (r_type)
            OP_LB:   ld_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ld_val = {24'd0, byte_v};
            OP_LH:   ld_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  ld_val = {16'd0, half_v};
            OP_LWL:  ld_val = (data_readdata << {k, 3'b000}) | (r_rt & ((32'd1 << {k, 3'b000}) - 32'd1));
            OP_LWR:  ld_val = (data_readdata >> {~k, 3'b000}) | (r_rt & ~(32'hFFFF_FFFF >> {~k, 3'b000}));
            default: ld_val = data_readdata;
        endcase
    end

    assign mask           = (r_type == OP_SH) ? (32'hFFFF_0000 >> {k[1], 4'b0000}) : (32'hFF00_0000 >> {k, 3'b000});
    assign lane           = (r_type == OP_SH) ? {2{r_wdata[15:0]}} : {4{r_wdata[7:0]}};
    assign merged         = (rmw_word & ~mask) | (lane & mask);
    assign data_writedata = (state == WR) ? r_wdata : merged;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            r_type    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rt      <= '0;
            r_err     <= 1'b0;
            rmw_word  <= '0;
            load_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && op_valid) begin
                r_type  <= op_type;
                r_addr  <= op_addr;
                r_wdata <= op_wdata;
                r_rt    <= op_rt;
                r_err   <= bad;
            end
            if (state == RMW_RD) rmw_word <= data_readdata;
            if (state == RD) load_data <= ld_val;
        end
    end
endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb_mips_cpu_lsu: directed checks of mips_cpu_lsu against a word-wide combinational-read memory model.
module tb_mips_cpu_lsu;
    logic        clk = 1'b0;
    logic        reset_n, op_valid, op_ready, done, err, data_read, data_write, preload;
    logic [3:0]  op_type;
    logic [31:0] op_addr, op_wdata, op_rt, load_data, data_address, data_writedata, data_readdata;
    logic [31:0] mem [0:4095];
    int          checks = 0, errors = 0;
    int          lat, nrd, nwr;
    bit          ovl, busy_ready;
    logic [31:0] wdat, prev;

    always #5 clk = ~clk;

    mips_cpu_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_type(op_type), .op_addr(op_addr), .op_wdata(op_wdata), .op_rt(op_rt),
        .done(done), .load_data(load_data), .err(err), .data_address(data_address),
        .data_read(data_read), .data_write(data_write), .data_writedata(data_writedata),
        .data_readdata(data_readdata)
    );

    assign data_readdata = mem[data_address[13:2]];

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h400] <= 32'h11223344;
            mem[12'h800] <= 32'h80FF7F01;
        end else if (data_write) begin
            mem[data_address[13:2]] <= data_writedata;
        end
    end

    // Issues one op and observes it until done (bounded); lat stays 0 on timeout.
    task automatic do_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
        @(negedge clk);
        op_type = t; op_addr = a; op_wdata = w; op_rt = r; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; ovl = 0; busy_ready = 0; wdat = 32'h0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            nrd += int'(data_read);
            nwr += int'(data_write);
            if (data_read && data_write) ovl = 1;
            if (data_write) wdat = data_writedata;
            if (op_ready) busy_ready = 1;
            if (done) lat = c;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; op_valid = 1'b0; op_type = '0; op_addr = '0; op_wdata = '0; op_rt = '0; preload = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        checks++; if ({op_ready, done, err, data_read, data_write} !== 5'b10000) begin errors++; $display("FAIL reset_ctrl got %b want 10000", {op_ready, done, err, data_read, data_write}); end
        checks++; if ({load_data, data_address, data_writedata} !== 96'h0) begin errors++; $display("FAIL reset_data got %h want 0", {load_data, data_address, data_writedata}); end
        reset_n = 1'b1;
    endtask

    typedef struct { logic [3:0] t; logic [31:0] a; logic [31:0] e; } ld_vec_t;

    task automatic test_loads();
        ld_vec_t v[8] = '{
            '{4'd0, 32'h1003, 32'h00000044}, '{4'd0, 32'h2000, 32'hFFFFFF80},
            '{4'd1, 32'h2000, 32'h00000080}, '{4'd0, 32'h2001, 32'hFFFFFFFF},
            '{4'd2, 32'h2002, 32'h00007F01}, '{4'd3, 32'h2000, 32'h000080FF},
            '{4'd2, 32'h2000, 32'hFFFF80FF}, '{4'd4, 32'h1000, 32'h11223344}};
        foreach (v[i]) begin
            do_op(v[i].t, v[i].a, 32'h0, 32'h0);
            checks++; if (lat !== 2) begin errors++; $display("FAIL load%0d_latency got %0d want 2", i, lat); end
            checks++; if (nrd !== 1 || nwr !== 0 || err !== 1'b0) begin errors++; $display("FAIL load%0d_strobes got rd=%0d wr=%0d err=%b want 1 0 0", i, nrd, nwr, err); end
            checks++; if (load_data !== v[i].e) begin errors++; $display("FAIL load%0d_data got %h want %h", i, load_data, v[i].e); end
            checks++; if (busy_ready) begin errors++; $display("FAIL load%0d_ready got 1 while busy want 0", i); end
        end
    endtask

    task automatic test_lwlr();
        prev = load_data;
        do_op(4'd8, 32'h1001, 32'h0, 32'hAABBCCDD);
`ifdef MIPS_LSU_LWLR_EN
        checks++; if (lat !== 2 || err !== 1'b0 || nrd !== 1) begin errors++; $display("FAIL lwl_timing got lat=%0d err=%b rd=%0d want 2 0 1", lat, err, nrd); end
        checks++; if (load_data !== 32'h223344DD) begin errors++; $display("FAIL lwl_data got %h want 223344dd", load_data); end
        do_op(4'd9, 32'h1001, 32'h0, 32'hAABBCCDD);
        checks++; if (lat !== 2 || err !== 1'b0 || nrd !== 1) begin errors++; $display("FAIL lwr_timing got lat=%0d err=%b rd=%0d want 2 0 1", lat, err, nrd); end
        checks++; if (load_data !== 32'hAABB1122) begin errors++; $display("FAIL lwr_data got %h want aabb1122", load_data); end
`else
        checks++; if (lat !== 1 || err !== 1'b1 || nrd !== 0) begin errors++; $display("FAIL lwl_err got lat=%0d err=%b rd=%0d want 1 1 0", lat, err, nrd); end
        checks++; if (load_data !== prev) begin errors++; $display("FAIL lwl_err_data got %h want %h", load_data, prev); end
`endif
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clk);
        op_type = 4'd5; op_addr = 32'h1000; op_wdata = 32'h55; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        checks++; if (data_read !== 1'b1) begin errors++; $display("FAIL rmw_rd got data_read=%b want 1", data_read); end
        @(negedge clk);
        checks++; if (data_write !== 1'b1 || data_writedata !== 32'h55223344) begin errors++; $display("FAIL rmw_wr got wr=%b data=%h want 1 55223344", data_write, data_writedata); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (data_write !== 1'b0 || data_read !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset got wr=%b rd=%b done=%b want 0 0 0", data_write, data_read, done); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (mem[12'h400] !== 32'h11223344) begin errors++; $display("FAIL reset_no_write got %h want 11223344", mem[12'h400]); end
        checks++; if (op_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL reset_release got ready=%b done=%b want 1 0", op_ready, done); end
    endtask

    task automatic test_stores();
        do_op(4'd4, 32'h2000, 32'h0, 32'h0);
        prev = load_data;
        checks++; if (prev !== 32'h80FF7F01) begin errors++; $display("FAIL lw_after_reset got %h want 80ff7f01", prev); end
        do_op(4'd5, 32'h1001, 32'h000000AA, 32'h0);
        checks++; if (lat !== 3 || nrd !== 1 || nwr !== 1 || ovl) begin errors++; $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d ovl=%b want 3 1 1 0", lat, nrd, nwr, ovl); end
        checks++; if (wdat !== 32'h11AA3344 || mem[12'h400] !== 32'h11AA3344) begin errors++; $display("FAIL sb_data got wd=%h mem=%h want 11aa3344", wdat, mem[12'h400]); end
        checks++; if (load_data !== prev || err !== 1'b0) begin errors++; $display("FAIL sb_keep got ld=%h err=%b want %h 0", load_data, err, prev); end
        do_op(4'd6, 32'h1002, 32'h0000BEEF, 32'h0);
        checks++; if (lat !== 3 || nrd !== 1 || nwr !== 1 || ovl) begin errors++; $display("FAIL sh_timing got lat=%0d rd=%0d wr=%0d ovl=%b want 3 1 1 0", lat, nrd, nwr, ovl); end
        checks++; if (mem[12'h400] !== 32'h11AABEEF) begin errors++; $display("FAIL sh_data got %h want 11aabeef", mem[12'h400]); end
        do_op(4'd7, 32'h2000, 32'hCAFEF00D, 32'h0);
        checks++; if (lat !== 2 || nrd !== 0 || nwr !== 1) begin errors++; $display("FAIL sw_timing got lat=%0d rd=%0d wr=%0d want 2 0 1", lat, nrd, nwr); end
        checks++; if (mem[12'h800] !== 32'hCAFEF00D || load_data !== prev) begin errors++; $display("FAIL sw_data got mem=%h ld=%h want cafef00d %h", mem[12'h800], load_data, prev); end
    endtask

    typedef struct { logic [3:0] t; logic [31:0] a; } err_vec_t;

    task automatic test_errors();
        err_vec_t v[6] = '{'{4'd2, 32'h1001}, '{4'd7, 32'h1002}, '{4'hF, 32'h1000},
                           '{4'd4, 32'h1002}, '{4'd6, 32'h1003}, '{4'hA, 32'h1000}};
        prev = load_data;
        foreach (v[i]) begin
            do_op(v[i].t, v[i].a, 32'h12345678, 32'h0);
            checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL err%0d_resp got lat=%0d err=%b want 1 1", i, lat, err); end
            checks++; if (nrd !== 0 || nwr !== 0) begin errors++; $display("FAIL err%0d_strobes got rd=%0d wr=%0d want 0 0", i, nrd, nwr); end
            checks++; if (mem[12'h400] !== 32'h11AABEEF || load_data !== prev) begin errors++; $display("FAIL err%0d_state got mem=%h ld=%h want 11aabeef %h", i, mem[12'h400], load_data, prev); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL err_pulse got done=%b err=%b want 0 0", done, err); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_lwlr();
        test_reset_mid_rmw();
        test_stores();
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
